// File: rtl/frog_pkg.sv
// Shared types and defaults for the frame collision scheduler.
// State encoding for the hit-report FSM plus colour and frog-index defaults.
package frog_pkg;

  typedef enum logic [1:0] {COLLECT, REPORT, HOLDOFF} coll_state_t;

  localparam int         RGB_W_DEF    = 8;
  localparam logic [7:0] OVERLAY_RGB  = 8'hE0;
  localparam int         FROG_IDX_DEF = 1;

endpackage

// File: rtl/priority_pixel_mux.sv
// Fixed-priority pixel select: the lowest requesting index wins, otherwise background.
// Purely combinational (0 cycles); the caller registers the outputs. No backpressure.
module priority_pixel_mux #(
  parameter int NUM_OBJ = 8,
  parameter int SEL_W   = 3,
  parameter int RGB_W   = 8
) (
  input  logic [NUM_OBJ-1:0]       draw_req,
  input  logic [NUM_OBJ*RGB_W-1:0] obj_rgb,
  input  logic [RGB_W-1:0]         bg_rgb,
  output logic [SEL_W-1:0]         sel,
  output logic [RGB_W-1:0]         rgb,
  output logic                     any
);

  // Scanning from the top down lets lower indices overwrite, so index 0 has priority.
  always_comb begin
    sel = '0;
    rgb = bg_rgb;
    any = |draw_req;
    for (int k = NUM_OBJ - 1; k >= 0; k--) begin
      if (draw_req[k]) begin
        sel = SEL_W'(k);
        rgb = obj_rgb[k*RGB_W +: RGB_W];
      end
    end
  end

endmodule

// File: rtl/frame_collision_scheduler.sv
// Priority pixel output plus debounced per-frame frog collision reports; COLLISION_OVERLAY_EN paints overlaps red.
// Pixel path 1 cycle; hit_valid pulses 1 cycle after the reporting startOfFrame. No backpressure.
module frame_collision_scheduler
  import frog_pkg::*;
#(
  parameter int NUM_OBJ        = 8,
  parameter int SEL_W          = 3,
  parameter int RGB_W          = RGB_W_DEF,
  parameter int FROG_IDX       = FROG_IDX_DEF,
  parameter int HOLDOFF_FRAMES = 4
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic                     play_en,
  input  logic [NUM_OBJ-1:0]       draw_req,
  input  logic [NUM_OBJ*RGB_W-1:0] obj_rgb,
  input  logic [RGB_W-1:0]         bg_rgb,
  output logic [RGB_W-1:0]         pix_rgb,
  output logic [SEL_W-1:0]         select_mux,
  output logic                     obj_valid,
  output logic [NUM_OBJ-1:0]       hit_vec,
  output logic                     hit_valid
);

  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF_FRAMES);

  logic [SEL_W-1:0]   mux_sel;
  logic [RGB_W-1:0]   mux_rgb;
  logic [RGB_W-1:0]   pix_n;
  logic               mux_any;
  logic [NUM_OBJ-1:0] ov;
  logic [NUM_OBJ-1:0] ov_gated;
  logic [NUM_OBJ-1:0] acc;
  logic [NUM_OBJ-1:0] acc_n;
  logic [NUM_OBJ-1:0] hit_vec_n;
  logic               hit_valid_n;
  logic [3:0]         cnt;
  logic [3:0]         cnt_n;
  coll_state_t        state;
  coll_state_t        state_n;

  priority_pixel_mux #(
    .NUM_OBJ (NUM_OBJ),
    .SEL_W   (SEL_W),
    .RGB_W   (RGB_W)
  ) u_mux (
    .draw_req (draw_req),
    .obj_rgb  (obj_rgb),
    .bg_rgb   (bg_rgb),
    .sel      (mux_sel),
    .rgb      (mux_rgb),
    .any      (mux_any)
  );

  always_comb begin
    ov           = draw_req & {NUM_OBJ{draw_req[FROG_IDX]}};
    ov[FROG_IDX] = 1'b0;
  end

  assign ov_gated = ov & {NUM_OBJ{play_en}};

`ifdef COLLISION_OVERLAY_EN
  assign pix_n = (|ov) ? RGB_W'(OVERLAY_RGB) : mux_rgb;
`else
  assign pix_n = mux_rgb;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pix_rgb    <= '0;
      select_mux <= '0;
      obj_valid  <= 1'b0;
    end else begin
      pix_rgb    <= pix_n;
      select_mux <= mux_sel;
      obj_valid  <= mux_any;
    end
  end

  // A startOfFrame overlap always belongs to the frame it opens, hence the ov_gated loads.
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    hit_vec_n   = '0;
    hit_valid_n = 1'b0;
    case (state)
      COLLECT: begin
        if (startOfFrame) begin
          if (acc != '0) begin
            state_n     = REPORT;
            hit_vec_n   = acc;
            hit_valid_n = 1'b1;
            acc_n       = '0;
          end else begin
            acc_n = ov_gated;
          end
        end else begin
          acc_n = acc | ov_gated;
        end
      end
      REPORT: begin
        acc_n = '0;
        if (startOfFrame && HOLD_INIT == 4'd1) begin
          state_n = COLLECT;
          acc_n   = ov_gated;
          cnt_n   = '0;
        end else begin
          state_n = HOLDOFF;
          cnt_n   = startOfFrame ? HOLD_INIT - 4'd1 : HOLD_INIT;
        end
      end
      HOLDOFF: begin
        acc_n = '0;
        if (startOfFrame) begin
          if (cnt == 4'd1) begin
            state_n = COLLECT;
            acc_n   = ov_gated;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
      end
      default: begin
        state_n = COLLECT;
        acc_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= COLLECT;
      acc       <= '0;
      cnt       <= '0;
      hit_vec   <= '0;
      hit_valid <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      hit_vec   <= hit_vec_n;
      hit_valid <= hit_valid_n;
    end
  end

endmodule

// File: tb/tb_frame_collision_scheduler.sv
// Directed bench for frame_collision_scheduler: queued expectations checked by a negedge monitor.
module tb_frame_collision_scheduler;

  typedef struct {
    int         due;
    logic [7:0] rgb;
    logic [2:0] sel;
    logic       vld;
  } pix_exp_t;

  typedef struct {
    int         due;
    logic [7:0] vec;
  } hit_exp_t;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        play_en = 1'b0;
  logic [7:0]  draw_req = '0;
  logic [63:0] obj_rgb = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h03, 8'h1C, 8'hA5};
  logic [7:0]  bg_rgb = 8'h92;
  logic [7:0]  pix_rgb;
  logic [2:0]  select_mux;
  logic        obj_valid;
  logic [7:0]  hit_vec;
  logic        hit_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  pix_exp_t pix_q[$];
  hit_exp_t hit_q[$];
  pix_exp_t pe;
  hit_exp_t he;

  frame_collision_scheduler dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .play_en      (play_en),
    .draw_req     (draw_req),
    .obj_rgb      (obj_rgb),
    .bg_rgb       (bg_rgb),
    .pix_rgb      (pix_rgb),
    .select_mux   (select_mux),
    .obj_valid    (obj_valid),
    .hit_vec      (hit_vec),
    .hit_valid    (hit_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic logic [7:0] ovl(input logic [7:0] base, input logic has_ov);
`ifdef COLLISION_OVERLAY_EN
    return has_ov ? 8'hE0 : base;
`else
    return has_ov ? base : base;
`endif
  endfunction

  task automatic step(input logic sof, input logic pe_in, input logic [7:0] req);
    startOfFrame = sof;
    play_en      = pe_in;
    draw_req     = req;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] req, input logic [7:0] rgb, input logic [2:0] sel, input logic vld);
    pix_q.push_back('{due: cyc + 1, rgb: rgb, sel: sel, vld: vld});
    step(1'b0, 1'b0, req);
  endtask

  task automatic exp_hit(input logic [7:0] vec);
    hit_q.push_back('{due: cyc + 1, vec: vec});
  endtask

  task automatic empty_frames(input int n);
    repeat (n) begin
      step(1'b1, 1'b1, 8'h00);
      repeat (3) step(1'b0, 1'b1, 8'h00);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_pix_rgb"}, pix_rgb, 8'h00);
    chk({tag, "_select_mux"}, {5'b0, select_mux}, 8'h00);
    chk({tag, "_obj_valid"}, {7'b0, obj_valid}, 8'h00);
    chk({tag, "_hit_vec"}, hit_vec, 8'h00);
    chk({tag, "_hit_valid"}, {7'b0, hit_valid}, 8'h00);
  endtask

  always @(negedge clk) begin
    if (pix_q.size() > 0 && pix_q[0].due < cyc) begin
      pe = pix_q.pop_front();
      chk("pix_missing", 8'h00, 8'h01);
    end
    if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      pe = pix_q.pop_front();
      chk("pix_rgb", pix_rgb, pe.rgb);
      chk("select_mux", {5'b0, select_mux}, {5'b0, pe.sel});
      chk("obj_valid", {7'b0, obj_valid}, {7'b0, pe.vld});
    end
    if (hit_q.size() > 0 && hit_q[0].due < cyc) begin
      he = hit_q.pop_front();
      chk("hit_missing", 8'h00, he.vec);
    end
    if (hit_valid) begin
      if (hit_q.size() > 0 && hit_q[0].due == cyc) begin
        he = hit_q.pop_front();
        chk("hit_vec", hit_vec, he.vec);
      end else begin
        chk("hit_unexpected", hit_vec, 8'h00);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    resetN = 1'b1;
    step(1'b0, 1'b0, 8'h00);

    // Pixel priority and background
    pix(8'b0000_0110, ovl(8'h1C, 1'b1), 3'd1, 1'b1);
    pix(8'h00, 8'h92, 3'd0, 1'b0);
    pix(8'h80, 8'h77, 3'd7, 1'b1);
    pix(8'h30, 8'h44, 3'd4, 1'b1);
    pix(8'h03, ovl(8'hA5, 1'b1), 3'd0, 1'b1);
    pix(8'h0C, 8'h03, 3'd2, 1'b1);
    pix(8'h02, 8'h1C, 3'd1, 1'b1);
    step(1'b0, 1'b0, 8'h00);

    // Single report one cycle after startOfFrame
    step(1'b1, 1'b1, 8'h00);
    repeat (3) step(1'b0, 1'b1, 8'h22);
    repeat (2) step(1'b0, 1'b1, 8'h00);
    exp_hit(8'h20);
    step(1'b1, 1'b1, 8'h00);
    repeat (2) step(1'b0, 1'b1, 8'h00);
    empty_frames(4);

    // Persistent overlap: reports at frames 1, 6, 11 only
    for (int i = 0; i < 12; i++) begin
      if (i == 1 || i == 6 || i == 11) exp_hit(8'h20);
      step(1'b1, 1'b1, 8'h00);
      repeat (4) step(1'b0, 1'b1, 8'h22);
    end
    empty_frames(4);

    // Overlap only in the startOfFrame cycle belongs to the new frame
    step(1'b1, 1'b1, 8'h22);
    repeat (3) step(1'b0, 1'b1, 8'h00);
    exp_hit(8'h20);
    step(1'b1, 1'b1, 8'h00);
    repeat (3) step(1'b0, 1'b1, 8'h00);
    empty_frames(4);

    // play_en low: no accumulation; earlier accumulation still reported
    step(1'b1, 1'b0, 8'h00);
    repeat (4) step(1'b0, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h00);
    repeat (2) step(1'b0, 1'b1, 8'h06);
    repeat (2) step(1'b0, 1'b0, 8'h22);
    exp_hit(8'h04);
    step(1'b1, 1'b0, 8'h00);
    repeat (2) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h22);

    // Reset in the middle of holdoff
    resetN = 1'b0;
    @(negedge clk);
    check_zero_outputs("midreset");
    @(posedge clk);
    #1;
    resetN = 1'b1;
    step(1'b1, 1'b1, 8'h00);
    repeat (3) step(1'b0, 1'b1, 8'h22);
    exp_hit(8'h20);
    step(1'b1, 1'b1, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00);

    chk("pix_queue_left", 8'(pix_q.size()), 8'h00);
    chk("hit_queue_left", 8'(hit_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_collision_scheduler.md
Name: frame_collision_scheduler

Overview:
- Sits between the per-object sprite drawers and the VGA pixel output.
- Each cycle, arbitrates the objects' draw requests by fixed priority and drives the selected object's pixel colour, registered, plus its mux select index.
- Over each frame, accumulates frog-vs-object overlaps and reports them once per frame at startOfFrame. A holdoff FSM then suppresses re-reporting, so the game FSM sees single, debounced hit events.

Parameters:
- NUM_OBJ, 8, number of drawable objects; index 0 is the highest priority.
- SEL_W, 3, width of select_mux; must satisfy 2**SEL_W >= NUM_OBJ.
- RGB_W, 8, pixel colour width (RRRGGGBB).
- FROG_IDX, 1, object index of the frog.
- HOLDOFF_FRAMES, 4, number of frames during which overlaps are ignored after a report; legal range 1..15.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at frame start
- play_en  in  1  when 0, overlaps are not accumulated
- draw_req  in  NUM_OBJ  per-object draw request for the current pixel
- obj_rgb  in  NUM_OBJ*RGB_W  packed object colours; object k occupies bits [k*RGB_W +: RGB_W]
- bg_rgb  in  RGB_W  background colour
- pix_rgb  out  RGB_W  registered output pixel
- select_mux  out  SEL_W  registered index of the winning object; 0 when no object requests
- obj_valid  out  1  registered; 1 when any draw_req was set
- hit_vec  out  NUM_OBJ  overlap mask, valid only while hit_valid=1; bit FROG_IDX is always 0
- hit_valid  out  1  one-cycle report pulse

Behaviour:
- Clock and reset: one clock, clk. resetN is asynchronous and active-low.
- Reset values: pix_rgb=0, select_mux=0, obj_valid=0, hit_vec=0, hit_valid=0. State=COLLECT, accumulator=0, holdoff counter=0.
- Pixel path, latency exactly 1 cycle:
  - Winner = lowest index k with draw_req[k]=1.
  - Next cycle: pix_rgb=obj_rgb[k], select_mux=k, obj_valid=1.
  - If no request: pix_rgb=bg_rgb, select_mux=0, obj_valid=0.
- Overlap detect (combinational): ov[k] = draw_req[FROG_IDX] & draw_req[k], for k≠FROG_IDX; ov[FROG_IDX]=0.
- FSM states: COLLECT, REPORT, HOLDOFF.
- COLLECT:
  - When play_en=1 and startOfFrame=0, acc |= ov every cycle.
  - On startOfFrame with acc≠0: go to REPORT, latch hit_vec=acc, clear acc.
  - On startOfFrame with acc=0: stay in COLLECT.
  - An overlap in the same cycle as startOfFrame is credited to the new frame: acc is loaded with ov & {NUM_OBJ{play_en}}.
- REPORT (one cycle): hit_valid=1 with hit_vec held; then go to HOLDOFF with counter=HOLDOFF_FRAMES.
- HOLDOFF:
  - acc is held at 0 and overlaps are ignored.
  - Each startOfFrame decrements the counter.
  - When a startOfFrame arrives with counter==1, go to COLLECT. Accumulation starts with that frame, including the same-cycle ov.
- hit_valid deasserts and hit_vec returns to 0 in every state other than REPORT.
- play_en=0 at a report point: acc still reports whatever was already accumulated; only new accumulation is gated.
- Reset mid-frame or mid-holdoff: return immediately to reset values; no partial report is emitted.
- A startOfFrame while in REPORT is counted as the first HOLDOFF decrement.

Optional Feature:
- Macro: COLLISION_OVERLAY_EN.
- Defined: when any ov bit is set in a cycle, the next-cycle pix_rgb is forced to 8'hE0 (red) regardless of the winner; select_mux and obj_valid are unchanged.
- Undefined: the pixel path is pure priority selection and the overlay logic is absent.

Decomposition:
- Package frog_pkg:
  - typedef enum logic [1:0] {COLLECT, REPORT, HOLDOFF} coll_state_t
  - localparam RGB_W_DEF=8
  - localparam OVERLAY_RGB=8'hE0
  - localparam FROG_IDX_DEF=1
- Sub-module priority_pixel_mux: combinational priority encoder plus RGB select; the top level registers its outputs.
- The FSM, accumulator and holdoff counter stay in the top level.

Test Plan (defaults unless stated):
1. Pixel priority: draw_req=8'b0000_0110, obj_rgb[1]=8'h1C, obj_rgb[2]=8'h03 -> next cycle pix_rgb=8'h1C, select_mux=1, obj_valid=1. Then draw_req=0, bg_rgb=8'h92 -> pix_rgb=8'h92, select_mux=0, obj_valid=0.
2. Single report: in one frame, overlap with object 5 (draw_req=8'h22) for 3 cycles, then startOfFrame -> exactly one hit_valid pulse, 1 cycle after startOfFrame, with hit_vec=8'h20.
3. Holdoff: overlaps with object 5 persist in every frame -> reports occur in frames 1, 6, 11 (5 frames apart) with HOLDOFF_FRAMES=4, and no hit_valid in between.
4. Boundary: an overlap only in the startOfFrame cycle, with acc=0 -> no pulse at that startOfFrame; hit_vec=8'h20 is reported at the following startOfFrame.
5. play_en=0 throughout a frame with overlaps -> no report. Asserting resetN=0 during HOLDOFF -> all outputs 0, state COLLECT, and a fresh overlap is reported at the next frame.
6. With COLLISION_OVERLAY_EN: draw_req=8'h03 -> pix_rgb=8'hE0, select_mux=0. Without the macro, the same stimulus gives pix_rgb=obj_rgb[0].
